// File: rtl/ir_pkg.sv
// Shared types and constants for the NEC IR command controller.
package ir_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        HOLD      = 2'd2,
        ISSUE_RPT = 2'd3
    } ctl_state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] addr_n;
        logic [7:0] cmd;
        logic [7:0] cmd_n;
    } nec_frame_t;

    // Nominal NEC repeat-code spacing (108 ms) and board clock.
    localparam int NEC_REPEAT_PERIOD_CYC = 5_400_000;
    localparam int CLK_HZ                = 50_000_000;

endpackage

// File: rtl/ir_cmd_controller_frame_check.sv
// Combinational NEC frame integrity check: command complement pair, and
// optionally the address complement pair plus a device address match.
module ir_frame_check
    import ir_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR    = 8'h00,
    parameter int         ADDR_FILTER = 1
) (
    input  nec_frame_t i_frame,
    output logic       o_good
);

    logic w_cmd_ok;
    logic w_addr_ok;

    assign w_cmd_ok  = (i_frame.cmd == ~i_frame.cmd_n);
    assign w_addr_ok = (i_frame.addr == ~i_frame.addr_n) && (i_frame.addr == DEV_ADDR);
    assign o_good    = w_cmd_ok && ((ADDR_FILTER == 0) || w_addr_ok);

endmodule

// File: rtl/ir_cmd_controller.sv
// NEC IR command sequencer: validates decoded frames, tracks held keys via
// repeat codes and issues commands over a valid/ready handshake.
// Optional feature macro: IRCTL_AUTOREPEAT_EN (held-key auto-repeat with
// release timeout). Without it, repeat codes are ignored and a transfer
// returns straight to IDLE.
module ir_cmd_controller
    import ir_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR     = 8'h00,
    parameter int         ADDR_FILTER  = 1,
    parameter int         HOLD_TIMEOUT = 6_000_000,
    parameter int         REPEAT_DIV   = 1
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       frm_valid,
    input  logic       frm_repeat,
    input  logic [7:0] frm_addr,
    input  logic [7:0] frm_addr_n,
    input  logic [7:0] frm_cmd,
    input  logic [7:0] frm_cmd_n,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_code,
    output logic       cmd_is_repeat,
    output logic [7:0] LEDR,
    output logic [7:0] err_cnt
);

    ctl_state_t r_state, w_state_nxt;
    nec_frame_t w_frame;
    logic       w_good;
    logic       w_data;
    logic       w_xfer;
    logic       w_load;
    logic       w_err;
    logic [7:0] r_cmd_code;
    logic [7:0] r_ledr;
    logic [7:0] r_err_cnt;

    assign w_frame = {frm_addr, frm_addr_n, frm_cmd, frm_cmd_n};

    ir_frame_check #(
        .DEV_ADDR    (DEV_ADDR),
        .ADDR_FILTER (ADDR_FILTER)
    ) u_frame_check (
        .i_frame (w_frame),
        .o_good  (w_good)
    );

    assign w_data    = frm_valid && !frm_repeat;
    assign cmd_valid = (r_state == ISSUE) || (r_state == ISSUE_RPT);
    assign w_xfer    = cmd_valid && cmd_ready;
    assign cmd_code  = r_cmd_code;
    assign LEDR      = r_ledr;
    assign err_cnt   = r_err_cnt;

`ifdef IRCTL_AUTOREPEAT_EN
    localparam int TW = $clog2(HOLD_TIMEOUT + 1);
    localparam int CW = $clog2(REPEAT_DIV + 1);

    logic          w_rpt;
    logic [TW-1:0] r_timer;
    logic [CW-1:0] r_rpt_cnt;
    logic          r_is_repeat;
    logic          w_timer_clr;
    logic          w_cnt_clr;
    logic          w_cnt_inc;
    logic          w_set_rpt;
    logic          w_timeout;
    logic          w_div_hit;

    assign w_rpt         = frm_valid && frm_repeat;
    assign w_timeout     = (r_timer == TW'(HOLD_TIMEOUT - 1));
    // Counter reaches REPEAT_DIV on this repeat code
    assign w_div_hit     = (r_rpt_cnt == CW'(REPEAT_DIV - 1));
    assign cmd_is_repeat = r_is_repeat;
`else
    assign cmd_is_repeat = 1'b0;
`endif

    // Next-state and datapath strobes; a data frame always overrides a pending timeout
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_err       = 1'b0;
`ifdef IRCTL_AUTOREPEAT_EN
        w_timer_clr = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_set_rpt   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_data) begin
                    if (w_good) begin
                        w_load      = 1'b1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ISSUE, ISSUE_RPT: begin
                if (w_xfer) begin
`ifdef IRCTL_AUTOREPEAT_EN
                    w_state_nxt = HOLD;
                    w_timer_clr = 1'b1;
                    w_cnt_clr   = 1'b1;
`else
                    w_state_nxt = IDLE;
`endif
                    // A frame landing on the transfer cycle is handled as if already past the handshake
                    if (w_data) begin
                        if (w_good) begin
                            w_load      = 1'b1;
                            w_state_nxt = ISSUE;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end else if (w_data) begin
                    // Output still stalled: the new frame has nowhere to go
                    w_err = 1'b1;
                end
            end
`ifdef IRCTL_AUTOREPEAT_EN
            HOLD: begin
                if (w_data) begin
                    if (w_good) begin
                        w_load      = 1'b1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (w_rpt) begin
                    w_timer_clr = 1'b1;
                    if (w_div_hit) begin
                        w_cnt_clr   = 1'b1;
                        w_set_rpt   = 1'b1;
                        w_state_nxt = ISSUE_RPT;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Command latch, LED mirror and saturating error counter
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_cmd_code <= 8'h00;
            r_ledr     <= 8'h00;
            r_err_cnt  <= 8'h00;
        end else begin
            if (w_load) begin
                r_cmd_code <= frm_cmd;
                r_ledr     <= frm_cmd;
            end
            if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

`ifdef IRCTL_AUTOREPEAT_EN
    // Hold timer, repeat divider and repeat flag for the held key
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_timer     <= '0;
            r_rpt_cnt   <= '0;
            r_is_repeat <= 1'b0;
        end else begin
            if (w_timer_clr)                          r_timer <= '0;
            else if (r_state == HOLD && !w_timeout)   r_timer <= r_timer + 1'b1;
            if (w_cnt_clr || w_load)                  r_rpt_cnt <= '0;
            else if (w_cnt_inc)                       r_rpt_cnt <= r_rpt_cnt + 1'b1;
            if (w_load)                               r_is_repeat <= 1'b0;
            else if (w_set_rpt)                       r_is_repeat <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ir_cmd_controller.sv
// Scoreboard bench for ir_cmd_controller: stimulus pushes expected commands,
// a negedge monitor pops and compares on every handshake transfer.
module tb_ir_cmd_controller;

`ifdef IRCTL_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] code;
        logic       rpt;
    } exp_t;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b0;
    logic       frm_valid = 1'b0;
    logic       frm_repeat = 1'b0;
    logic [7:0] frm_addr = 8'h00;
    logic [7:0] frm_addr_n = 8'h00;
    logic [7:0] frm_cmd = 8'h00;
    logic [7:0] frm_cmd_n = 8'h00;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       cmd_is_repeat;
    logic [7:0] LEDR;
    logic [7:0] err_cnt;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    ir_cmd_controller #(
        .DEV_ADDR     (8'h00),
        .ADDR_FILTER  (1),
        .HOLD_TIMEOUT (1000),
        .REPEAT_DIV   (2)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .RESET         (RESET),
        .frm_valid     (frm_valid),
        .frm_repeat    (frm_repeat),
        .frm_addr      (frm_addr),
        .frm_addr_n    (frm_addr_n),
        .frm_cmd       (frm_cmd),
        .frm_cmd_n     (frm_cmd_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_code      (cmd_code),
        .cmd_is_repeat (cmd_is_repeat),
        .LEDR          (LEDR),
        .err_cnt       (err_cnt)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] c, input logic r);
        exp_q.push_back({c, r});
    endtask

    // Frame is sampled on the second rising edge; returns 2 time units after it
    task automatic send(input logic [7:0] a, input logic [7:0] an,
                        input logic [7:0] c, input logic [7:0] cn, input logic rpt);
        @(posedge CLOCK_50); #2;
        frm_addr = a; frm_addr_n = an; frm_cmd = c; frm_cmd_n = cn;
        frm_repeat = rpt; frm_valid = 1'b1;
        @(posedge CLOCK_50); #2;
        frm_valid = 1'b0; frm_repeat = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
    endtask

    // Monitor: every transfer must match the head of the expected queue
    always @(negedge CLOCK_50) begin
        if (!RESET && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_cmd: got code %0h rpt %0b, expected no transfer",
                         cmd_code, cmd_is_repeat);
            end else begin
                mon_e = exp_q.pop_front();
                chk("xfer_code", {24'h0, cmd_code}, {24'h0, mon_e.code});
                chk("xfer_is_repeat", {31'h0, cmd_is_repeat}, {31'h0, mon_e.rpt});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 RESET = 1'b1;
        #4;
        chk("rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
        chk("rst_cmd_code", {24'h0, cmd_code}, 32'h0);
        chk("rst_is_repeat", {31'h0, cmd_is_repeat}, 32'h0);
        chk("rst_ledr", {24'h0, LEDR}, 32'h0);
        chk("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
        @(negedge CLOCK_50); @(negedge CLOCK_50);
        RESET = 1'b0;

        // Good frame 45, one-cycle valid with ready high
        push(8'h45, 1'b0);
        send(8'h00, 8'hFF, 8'h45, 8'hBA, 1'b0);
        chk("k45_valid", {31'h0, cmd_valid}, 32'h1);
        chk("k45_ledr", {24'h0, LEDR}, 32'h45);
        @(posedge CLOCK_50); #2;
        chk("k45_valid_one_cycle", {31'h0, cmd_valid}, 32'h0);
        chk("k45_err_cnt", {24'h0, err_cnt}, 32'h0);

        // Bad command complement, then wrong device address
        send(8'h00, 8'hFF, 8'h45, 8'hBB, 1'b0);
        send(8'h01, 8'hFE, 8'h45, 8'hBA, 1'b0);
        #1;
        chk("bad_err_cnt", {24'h0, err_cnt}, 32'h2);
        chk("bad_ledr", {24'h0, LEDR}, 32'h45);
        chk("bad_no_valid", {31'h0, cmd_valid}, 32'h0);
        wait_cyc(1100);

        // Held key 16 with repeats; first repeat lands exactly on the timeout cycle
        push(8'h16, 1'b0);
        send(8'h00, 8'hFF, 8'h16, 8'hE9, 1'b0);
        wait_cyc(999);
        send(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("rptA_no_valid", {31'h0, cmd_valid}, 32'h0);
        wait_cyc(498);
        if (AR) push(8'h16, 1'b1);
        send(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("rptB_valid", {31'h0, cmd_valid}, {31'h0, AR});
        chk("rptB_is_repeat", {31'h0, cmd_is_repeat}, {31'h0, AR});
        chk("rptB_code", {24'h0, cmd_code}, 32'h16);
        wait_cyc(498);
        send(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        wait_cyc(498);
        if (AR) push(8'h16, 1'b1);
        send(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("rptD_valid", {31'h0, cmd_valid}, {31'h0, AR});
        // Released key: two repeats would be enough to issue if still held
        wait_cyc(1100);
        send(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        send(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        wait_cyc(5); #2;
        chk("released_no_valid", {31'h0, cmd_valid}, 32'h0);
        chk("rpt_queue_drained", exp_q.size(), 32'h0);

        // Backpressure: 0C stalls, 18 is dropped
        cmd_ready = 1'b0;
        push(8'h0C, 1'b0);
        send(8'h00, 8'hFF, 8'h0C, 8'hF3, 1'b0);
        chk("k0C_valid", {31'h0, cmd_valid}, 32'h1);
        send(8'h00, 8'hFF, 8'h18, 8'hE7, 1'b0);
        chk("drop_err_cnt", {24'h0, err_cnt}, 32'h3);
        chk("drop_code_held", {24'h0, cmd_code}, 32'h0C);
        chk("drop_ledr", {24'h0, LEDR}, 32'h0C);
        wait_cyc(5); #2;
        chk("stall_valid", {31'h0, cmd_valid}, 32'h1);
        chk("stall_code", {24'h0, cmd_code}, 32'h0C);

        // Transfer of 0C and good frame 5E on the same edge
        push(8'h5E, 1'b0);
        @(posedge CLOCK_50); #2;
        frm_addr = 8'h00; frm_addr_n = 8'hFF; frm_cmd = 8'h5E; frm_cmd_n = 8'hA1;
        frm_repeat = 1'b0; frm_valid = 1'b1; cmd_ready = 1'b1;
        @(posedge CLOCK_50); #2;
        frm_valid = 1'b0;
        chk("b2b_valid", {31'h0, cmd_valid}, 32'h1);
        chk("b2b_code", {24'h0, cmd_code}, 32'h5E);
        chk("b2b_ledr", {24'h0, LEDR}, 32'h5E);
        chk("b2b_err_cnt", {24'h0, err_cnt}, 32'h3);
        @(posedge CLOCK_50); #2;
        cmd_ready = 1'b0;

        // Pending output (repeat of 5E, or new key 77) killed by async reset
        if (AR) begin
            send(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
            send(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        end else begin
            send(8'h00, 8'hFF, 8'h77, 8'h88, 1'b0);
        end
        chk("pre_rst_valid", {31'h0, cmd_valid}, 32'h1);
        chk("pre_rst_is_repeat", {31'h0, cmd_is_repeat}, {31'h0, AR});
        chk("pre_rst_code", {24'h0, cmd_code}, AR ? 32'h5E : 32'h77);
        #5 RESET = 1'b1;
        #1;
        chk("arst_valid", {31'h0, cmd_valid}, 32'h0);
        chk("arst_code", {24'h0, cmd_code}, 32'h0);
        chk("arst_is_repeat", {31'h0, cmd_is_repeat}, 32'h0);
        chk("arst_ledr", {24'h0, LEDR}, 32'h0);
        chk("arst_err_cnt", {24'h0, err_cnt}, 32'h0);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        cmd_ready = 1'b1;
        send(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        send(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        wait_cyc(5); #2;
        chk("post_rst_no_valid", {31'h0, cmd_valid}, 32'h0);
        chk("post_rst_err_cnt", {24'h0, err_cnt}, 32'h0);

        // err_cnt saturation
        for (int i = 0; i < 254; i++) send(8'h00, 8'hFF, 8'h01, 8'h01, 1'b0);
        chk("sat_254", {24'h0, err_cnt}, 32'd254);
        send(8'h00, 8'hFF, 8'h01, 8'h01, 1'b0);
        chk("sat_255", {24'h0, err_cnt}, 32'd255);
        send(8'h00, 8'hFF, 8'h01, 8'h01, 1'b0);
        send(8'h00, 8'hFF, 8'h01, 8'h01, 1'b0);
        chk("sat_hold", {24'h0, err_cnt}, 32'd255);

        wait_cyc(10);
        chk("final_queue_empty", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
